// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and the request fault check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {IDLE, ACCESS, RMW_RD, RMW_WR, RESP} lsu_state_t;

  function automatic logic lsu_fault(input logic        we,
                                     input logic [2:0]  f3,
                                     input logic [31:0] addr,
                                     input logic [31:0] mem_bytes);
    logic bad_f3;
    logic misal;
    if (we) bad_f3 = !(f3 inside {F3_B, F3_H, F3_W});
    else    bad_f3 = !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    misal = ((f3 == F3_H || f3 == F3_HU) && addr[0]) ||
            ((f3 == F3_W) && (addr[1:0] != 2'b00));
    return bad_f3 || misal || (addr >= mem_bytes);
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte-lane steering: extracts/extends load data and merges sub-word store
// data into a read word.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merge
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_lane)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];
  end

  always_comb begin
    case (i_funct3)
      F3_B:    o_load = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_load = {24'h0, w_byte};
      F3_H:    o_load = {{16{w_half[15]}}, w_half};
      F3_HU:   o_load = {16'h0, w_half};
      default: o_load = i_word;
    endcase
  end

  always_comb begin
    o_merge = i_word;
    case (i_funct3)
      F3_B: begin
        case (i_lane)
          2'd0:    o_merge[7:0]   = i_wdata[7:0];
          2'd1:    o_merge[15:8]  = i_wdata[7:0];
          2'd2:    o_merge[23:16] = i_wdata[7:0];
          default: o_merge[31:24] = i_wdata[7:0];
        endcase
      end
      F3_H: begin
        if (i_lane[1]) o_merge[31:16] = i_wdata[15:0];
        else           o_merge[15:0]  = i_wdata[15:0];
      end
      default: o_merge = i_wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word load and store requests into
// word-wide memory accesses, with read-modify-write for sub-word stores.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  lsu_state_t  r_state, w_next;
  logic [31:0] r_addr, r_wdata, r_rdata, r_merge;
  logic [2:0]  r_f3;
  logic        r_we, r_fault;
  logic        w_fault, w_accept;
  logic [31:0] w_load, w_merge;

  assign w_fault  = lsu_fault(req_we, req_funct3, req_addr, 32'(MEM_BYTES));
  assign w_accept = req_valid && req_ready;

  lsu_byte_lane u_lane (
    .i_word   (mem_rdata),
    .i_funct3 (r_f3),
    .i_lane   (r_addr[1:0]),
    .i_wdata  (r_wdata),
    .o_load   (w_load),
    .o_merge  (w_merge)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_fault)                            w_next = RESP;
          else if (!req_we || req_funct3 == F3_W) w_next = ACCESS;
          else                                    w_next = RMW_RD;
        end
      end
      ACCESS:  w_next = RESP;
      RMW_RD:  w_next = RMW_WR;
      RMW_WR:  w_next = RESP;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_merge <= '0;
      r_f3    <= '0;
      r_we    <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      if (r_state == IDLE && w_accept) begin
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_f3    <= req_funct3;
        r_we    <= req_we;
        r_fault <= w_fault;
        r_rdata <= '0;
      end
      if (r_state == ACCESS && !r_we) r_rdata <= w_load;
      if (r_state == RMW_RD)          r_merge <= w_merge;
    end
  end

  // Outputs decode from state only, so an async reset drops mem_we at once.
  always_comb begin
    req_ready  = (r_state == IDLE) && reset;
    resp_valid = (r_state == RESP);
    resp_fault = (r_state == RESP) && r_fault;
    resp_rdata = (r_state == RESP) ? r_rdata : '0;
    mem_we     = ((r_state == ACCESS) && r_we) || (r_state == RMW_WR);
    mem_addr   = (r_state inside {ACCESS, RMW_RD, RMW_WR}) ? {r_addr[31:2], 2'b00} : '0;
    mem_wdata  = '0;
    if (r_state == ACCESS && r_we) mem_wdata = r_wdata;
    else if (r_state == RMW_WR)    mem_wdata = r_merge;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a 32-word behavioural memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [32];
  int          wr_cnt = 0;
  int          resp_cnt = 0;
  logic [31:0] wr_addr = '0;
  logic        p_en = 1'b0;
  logic [4:0]  p_idx = '0;
  logic [31:0] p_val = '0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_BYTES(128)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_fault (resp_fault),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[6:2]];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr[6:2]] <= mem_wdata;
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= mem_addr;
    end else if (p_en) begin
      mem[p_idx] <= p_val;
    end
    if (resp_valid) resp_cnt <= resp_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [4:0] idx, input logic [31:0] val);
    @(negedge clk);
    p_en = 1'b1; p_idx = idx; p_val = val;
    @(posedge clk);
    #1 p_en = 1'b0;
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic flt, output int lat, output int wr);
    int wr0;
    @(negedge clk);
    wr0 = wr_cnt;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; rd = '0; flt = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = n; rd = resp_rdata; flt = resp_fault;
        break;
      end
    end
    @(negedge clk);
    wr = wr_cnt - wr0;
  endtask

  task automatic run(input string tag, input logic we, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_flt,
                     input int exp_lat, input int exp_wr);
    logic [31:0] rd;
    logic        flt;
    int          lat, wr;
    chk({tag, ".ready"}, 32'(req_ready), 32'd1);
    do_req(we, f3, a, wd, rd, flt, lat, wr);
    chk({tag, ".rdata"}, rd, exp_rd);
    chk({tag, ".fault"}, 32'(flt), 32'(exp_flt));
    chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".writes"}, 32'(wr), 32'(exp_wr));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    #12;
    chk("rst.ready", 32'(req_ready), 32'd0);
    chk("rst.resp_valid", 32'(resp_valid), 32'd0);
    chk("rst.resp_fault", 32'(resp_fault), 32'd0);
    chk("rst.resp_rdata", resp_rdata, 32'd0);
    chk("rst.mem_we", 32'(mem_we), 32'd0);
    chk("rst.mem_addr", mem_addr, 32'd0);
    chk("rst.mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst.ready", 32'(req_ready), 32'd1);

    poke(5'd4, 32'h8899AABB);
    poke(5'd8, 32'h11223344);
    poke(5'd9, 32'h00000000);

    run("LB_11",  1'b0, 3'b000, 32'h11, 32'h0, 32'hFFFFFFAA, 1'b0, 2, 0);
    run("LBU_11", 1'b0, 3'b100, 32'h11, 32'h0, 32'h000000AA, 1'b0, 2, 0);
    run("LH_12",  1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF8899, 1'b0, 2, 0);
    run("LHU_12", 1'b0, 3'b101, 32'h12, 32'h0, 32'h00008899, 1'b0, 2, 0);
    run("LW_10",  1'b0, 3'b010, 32'h10, 32'h0, 32'h8899AABB, 1'b0, 2, 0);
    run("LB_10",  1'b0, 3'b000, 32'h10, 32'h0, 32'hFFFFFFBB, 1'b0, 2, 0);
    run("LBU_13", 1'b0, 3'b100, 32'h13, 32'h0, 32'h00000088, 1'b0, 2, 0);

    run("SB_22", 1'b1, 3'b000, 32'h22, 32'hDEADBEEF, 32'h0, 1'b0, 3, 1);
    chk("SB_22.word", mem[8], 32'h11EF3344);
    chk("SB_22.addr", wr_addr, 32'h20);

    poke(5'd8, 32'h11223344);
    run("SH_20", 1'b1, 3'b001, 32'h20, 32'h0000CAFE, 32'h0, 1'b0, 3, 1);
    chk("SH_20.word", mem[8], 32'h1122CAFE);
    run("SH_22", 1'b1, 3'b001, 32'h22, 32'h0000BEEF, 32'h0, 1'b0, 3, 1);
    chk("SH_22.word", mem[8], 32'hBEEFCAFE);
    run("SW_24", 1'b1, 3'b010, 32'h24, 32'h12345678, 32'h0, 1'b0, 2, 1);
    chk("SW_24.word", mem[9], 32'h12345678);
    run("LW_24", 1'b0, 3'b010, 32'h24, 32'h0, 32'h12345678, 1'b0, 2, 0);

    poke(5'd8, 32'h11223344);
    run("F_LW_13",  1'b0, 3'b010, 32'h13, 32'h0, 32'h0, 1'b1, 1, 0);
    run("F_SH_21",  1'b1, 3'b001, 32'h21, 32'hFFFF, 32'h0, 1'b1, 1, 0);
    chk("F_SH_21.word", mem[8], 32'h11223344);
    run("F_LD_011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1, 0);
    run("F_SW_80",  1'b1, 3'b010, 32'h80, 32'hA5A5A5A5, 32'h0, 1'b1, 1, 0);
    run("F_ST_100", 1'b1, 3'b100, 32'h20, 32'hA5A5A5A5, 32'h0, 1'b1, 1, 0);
    chk("F.word8", mem[8], 32'h11223344);
    chk("F.word0", mem[0], 32'h00000000);
    run("LW_7C", 1'b0, 3'b010, 32'h7C, 32'h0, 32'h0, 1'b0, 2, 0);

    // Reset while the SB is in its read phase.
    begin
      int wr0, resp0;
      @(negedge clk);
      wr0 = wr_cnt; resp0 = resp_cnt;
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
      req_addr = 32'h20; req_wdata = 32'h000000EE;
      @(posedge clk);
      #1 req_valid = 1'b0;
      chk("RST_RMW.in_rd", mem_addr, 32'h20);
      reset = 1'b0;
      #1;
      chk("RST_RMW.mem_we", 32'(mem_we), 32'd0);
      chk("RST_RMW.mem_addr", mem_addr, 32'd0);
      chk("RST_RMW.ready", 32'(req_ready), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("RST_RMW.ready_after", 32'(req_ready), 32'd1);
      chk("RST_RMW.no_resp", 32'(resp_cnt - resp0), 32'd0);
      chk("RST_RMW.no_write", 32'(wr_cnt - wr0), 32'd0);
      chk("RST_RMW.word", mem[8], 32'h11223344);
    end
    run("LW_20_after", 1'b0, 3'b010, 32'h20, 32'h0, 32'h11223344, 1'b0, 2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
